// File: rtl/tcm_arb_pkg.sv
// Shared constants for the tightly-coupled-memory arbiter: response-phase
// encoding, grant vector bit positions and a counter-width helper.
package tcm_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RESP_I = 2'd1;
  localparam logic [1:0] RESP_D = 2'd2;

  localparam int GNT_I = 0;
  localparam int GNT_D = 1;

  function automatic int cnt_width(input int max_val);
    return (max_val > 2) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/tcm_arb_sel.sv
// Grant selection: one-hot {D, I} grant from both requests and a tie-break
// hint (prio_i=1 hands a simultaneous request to the I side).
module tcm_arb_sel
  import tcm_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic       prio_i,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (i_req && (!d_req || prio_i)) begin
      grant[GNT_I] = 1'b1;
    end else if (d_req) begin
      grant[GNT_D] = 1'b1;
    end
  end

endmodule

// File: rtl/tcm_arb.sv
// Single-port TCM arbiter between instruction fetch and data access, one
// access per cycle, one-cycle response. Build option: TCM_ARB_ROUND_ROBIN_EN.
module tcm_arb
  import tcm_arb_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_i_rd_i,
  input  logic [31:0]       mem_i_pc_i,
  output logic              mem_i_accept_o,
  output logic              mem_i_valid_o,
  output logic [31:0]       mem_i_inst_o,
  input  logic              mem_d_rd_i,
  input  logic [3:0]        mem_d_wr_i,
  input  logic [31:0]       mem_d_addr_i,
  input  logic [31:0]       mem_d_data_wr_i,
  input  logic [10:0]       mem_d_req_tag_i,
  output logic              mem_d_accept_o,
  output logic              mem_d_ack_o,
  output logic [31:0]       mem_d_data_rd_o,
  output logic [10:0]       mem_d_resp_tag_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_data_o,
  output logic [3:0]        ram_wr_o,
  input  logic [31:0]       ram_data_i
);

  logic              i_req;
  logic              d_req;
  logic              prio_i;
  logic [1:0]        grant;
  logic              gnt_i;
  logic              gnt_d;
  logic [1:0]        resp_reg;
  logic [1:0]        resp_next;
  logic [10:0]       tag_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr_next;
  logic              unused_bits;

  // Requests are masked during reset so nothing is accepted while rst_i is high.
  assign i_req = mem_i_rd_i & ~rst_i;
  assign d_req = (mem_d_rd_i | (|mem_d_wr_i)) & ~rst_i;

`ifdef TCM_ARB_ROUND_ROBIN_EN
  logic last_d_reg;

  assign prio_i = last_d_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_d_reg <= 1'b0;
    end else if (gnt_i || gnt_d) begin
      last_d_reg <= gnt_d;
    end
  end
`else
  localparam int CNT_W = cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX - 1);

  logic [CNT_W-1:0] starve_reg;
  logic [CNT_W-1:0] starve_next;

  // Once I has lost STARVE_MAX-1 ties in a row, it takes the next one.
  assign prio_i = (starve_reg == CNT_MAX);

  always_comb begin
    starve_next = '0;
    if (i_req && !gnt_i) begin
      starve_next = (starve_reg == CNT_MAX) ? starve_reg : starve_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_reg <= '0;
    end else begin
      starve_reg <= starve_next;
    end
  end
`endif

  tcm_arb_sel u_sel (
    .i_req  (i_req),
    .d_req  (d_req),
    .prio_i (prio_i),
    .grant  (grant)
  );

  assign gnt_i = grant[GNT_I];
  assign gnt_d = grant[GNT_D];

  assign mem_i_accept_o = gnt_i;
  assign mem_d_accept_o = gnt_d;

  always_comb begin
    addr_next = addr_reg;
    if (gnt_i) begin
      addr_next = mem_i_pc_i[ADDR_W+1:2];
    end else if (gnt_d) begin
      addr_next = mem_d_addr_i[ADDR_W+1:2];
    end
  end

  always_comb begin
    resp_next = IDLE;
    if (gnt_i) begin
      resp_next = RESP_I;
    end else if (gnt_d) begin
      resp_next = RESP_D;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_reg <= IDLE;
      tag_reg  <= '0;
      addr_reg <= '0;
    end else begin
      resp_reg <= resp_next;
      addr_reg <= addr_next;
      if (gnt_d) begin
        tag_reg <= mem_d_req_tag_i;
      end
    end
  end

  assign ram_addr_o = addr_next;
  assign ram_data_o = mem_d_data_wr_i;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign ram_wr_o[gi] = gnt_d & mem_d_wr_i[gi];
  end

  assign mem_i_valid_o    = (resp_reg == RESP_I);
  assign mem_d_ack_o      = (resp_reg == RESP_D);
  assign mem_i_inst_o     = ram_data_i;
  assign mem_d_data_rd_o  = ram_data_i;
  assign mem_d_resp_tag_o = tag_reg;

  assign unused_bits = &{1'b0, mem_i_pc_i[31:ADDR_W+2], mem_i_pc_i[1:0],
                         mem_d_addr_i[31:ADDR_W+2], mem_d_addr_i[1:0]};

endmodule

// File: tb/tb_tcm_arb.sv
// Self-checking bench for tcm_arb: vector table, arbitration sequences,
// reset-mid-access, then random traffic against a behavioural model.
module tb_tcm_arb;

  localparam int ADDR_W     = 14;
  localparam int STARVE_MAX = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              mem_i_rd_i = 1'b0;
  logic [31:0]       mem_i_pc_i = '0;
  logic              mem_i_accept_o;
  logic              mem_i_valid_o;
  logic [31:0]       mem_i_inst_o;
  logic              mem_d_rd_i = 1'b0;
  logic [3:0]        mem_d_wr_i = '0;
  logic [31:0]       mem_d_addr_i = '0;
  logic [31:0]       mem_d_data_wr_i = '0;
  logic [10:0]       mem_d_req_tag_i = '0;
  logic              mem_d_accept_o;
  logic              mem_d_ack_o;
  logic [31:0]       mem_d_data_rd_o;
  logic [10:0]       mem_d_resp_tag_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [31:0]       ram_data_o;
  logic [3:0]        ram_wr_o;
  logic [31:0]       ram_data_i = '0;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          exp_resp;      // 0 none, 1 fetch response due, 2 data response due
  logic        exp_d_read;
  logic [10:0] exp_tag;
  logic [13:0] exp_addr;
  logic [31:0] exp_data;
  int          losses;        // ties I has lost in a row
  int          last_was_d;

  tcm_arb #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .mem_i_rd_i       (mem_i_rd_i),
    .mem_i_pc_i       (mem_i_pc_i),
    .mem_i_accept_o   (mem_i_accept_o),
    .mem_i_valid_o    (mem_i_valid_o),
    .mem_i_inst_o     (mem_i_inst_o),
    .mem_d_rd_i       (mem_d_rd_i),
    .mem_d_wr_i       (mem_d_wr_i),
    .mem_d_addr_i     (mem_d_addr_i),
    .mem_d_data_wr_i  (mem_d_data_wr_i),
    .mem_d_req_tag_i  (mem_d_req_tag_i),
    .mem_d_accept_o   (mem_d_accept_o),
    .mem_d_ack_o      (mem_d_ack_o),
    .mem_d_data_rd_o  (mem_d_data_rd_o),
    .mem_d_resp_tag_o (mem_d_resp_tag_o),
    .ram_addr_o       (ram_addr_o),
    .ram_data_o       (ram_data_o),
    .ram_wr_o         (ram_wr_o),
    .ram_data_i       (ram_data_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] ram_word(input logic [13:0] a);
    return 32'hC0DE0000 ^ ({18'd0, a} * 32'h9E3779B1);
  endfunction

  // RAM stand-in: read data is a fixed function of the address presented last edge.
  always @(posedge clk_i) ram_data_i <= ram_word(ram_addr_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_resp = 0; exp_d_read = 1'b0; exp_tag = '0; exp_addr = '0;
    exp_data = '0; losses = 0; last_was_d = 0;
  endtask

  // Compare all outputs with the model for the current cycle, then advance it.
  task automatic model_check();
    bit ir, dr, gi, gd, i_wins;
    logic [13:0] a;
    ir = mem_i_rd_i;
    dr = mem_d_rd_i || (mem_d_wr_i != 4'd0);
`ifdef TCM_ARB_ROUND_ROBIN_EN
    i_wins = (last_was_d != 0);
`else
    i_wins = (losses == STARVE_MAX - 1);
`endif
    gi = ir && (!dr || i_wins);
    gd = dr && !gi;
    a  = gi ? mem_i_pc_i[15:2] : (gd ? mem_d_addr_i[15:2] : exp_addr);
    chk("accept_i", 32'(mem_i_accept_o), 32'(gi));
    chk("accept_d", 32'(mem_d_accept_o), 32'(gd));
    chk("ram_addr", 32'(ram_addr_o), 32'(a));
    chk("ram_wr", 32'(ram_wr_o), gd ? 32'(mem_d_wr_i) : 32'd0);
    if (gd && mem_d_wr_i != 4'd0) chk("ram_data", ram_data_o, mem_d_data_wr_i);
    chk("i_valid", 32'(mem_i_valid_o), 32'(exp_resp == 1));
    chk("d_ack", 32'(mem_d_ack_o), 32'(exp_resp == 2));
    chk("resp_tag", 32'(mem_d_resp_tag_o), 32'(exp_tag));
    if (exp_resp == 1) chk("i_inst", mem_i_inst_o, exp_data);
    if (exp_resp == 2 && exp_d_read) chk("d_rdata", mem_d_data_rd_o, exp_data);
    if (gi) $display("txn I pc=%08h ram_addr=%04h", mem_i_pc_i, a);
    if (gd) $display("txn D %s addr=%08h wr=%h tag=%03h ram_addr=%04h",
                     (mem_d_wr_i != 4'd0) ? "wr" : "rd", mem_d_addr_i, mem_d_wr_i, mem_d_req_tag_i, a);
    exp_resp   = gi ? 1 : (gd ? 2 : 0);
    exp_d_read = gd && (mem_d_wr_i == 4'd0);
    if (gd) exp_tag = mem_d_req_tag_i;
    exp_addr = a;
    exp_data = ram_word(a);
    losses   = (ir && !gi) ? ((losses < STARVE_MAX - 1) ? losses + 1 : losses) : 0;
    if (gi || gd) last_was_d = gd ? 1 : 0;
  endtask

  task automatic drive(input logic ir, input logic [31:0] pc, input logic dr,
                       input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                       input logic [10:0] tag);
    @(negedge clk_i);
    mem_i_rd_i = ir; mem_i_pc_i = pc; mem_d_rd_i = dr; mem_d_wr_i = dw;
    mem_d_addr_i = da; mem_d_data_wr_i = dd; mem_d_req_tag_i = tag;
    #2;
  endtask

  task automatic cycle(input logic ir, input logic [31:0] pc, input logic dr,
                       input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                       input logic [10:0] tag);
    drive(ir, pc, dr, dw, da, dd, tag);
    model_check();
  endtask

  typedef struct {
    logic        i_rd;  logic [31:0] pc;
    logic        d_rd;  logic [3:0]  d_wr;  logic [31:0] d_addr;  logic [10:0] tag;
    logic        acc_i; logic        acc_d; logic [13:0] addr;    logic [3:0]  wr;
    logic        nxt_valid; logic    nxt_ack; logic [10:0] nxt_tag;
  } vec_t;

  vec_t vecs[8];
  bit   exp_seq_d[8];

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 4'h0, 32'h0, 11'h000, 1'b1, 1'b0, 14'h0040, 4'h0, 1'b1, 1'b0, 11'h000};
    vecs[1] = '{1'b0, 32'h0, 1'b0, 4'h3, 32'h0000_0008, 11'h5A5, 1'b0, 1'b1, 14'h0002, 4'h3, 1'b0, 1'b1, 11'h5A5};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_1234, 11'h7FF, 1'b0, 1'b1, 14'h048D, 4'h0, 1'b0, 1'b1, 11'h7FF};
    vecs[3] = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 11'h000, 1'b0, 1'b0, 14'h048D, 4'h0, 1'b0, 1'b0, 11'h7FF};
    vecs[4] = '{1'b1, 32'h0000_FFFC, 1'b0, 4'h0, 32'h0, 11'h000, 1'b1, 1'b0, 14'h3FFF, 4'h0, 1'b1, 1'b0, 11'h7FF};
    vecs[5] = '{1'b1, 32'h0001_0004, 1'b0, 4'h0, 32'h0, 11'h000, 1'b1, 1'b0, 14'h0001, 4'h0, 1'b1, 1'b0, 11'h7FF};
    vecs[6] = '{1'b0, 32'h0, 1'b0, 4'hF, 32'hFFFF_FFF0, 11'h000, 1'b0, 1'b1, 14'h3FFC, 4'hF, 1'b0, 1'b1, 11'h000};
    vecs[7] = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 11'h000, 1'b0, 1'b0, 14'h3FFC, 4'h0, 1'b0, 1'b0, 11'h000};
`ifdef TCM_ARB_ROUND_ROBIN_EN
    exp_seq_d = '{1, 0, 1, 0, 1, 0, 1, 0};
`else
    exp_seq_d = '{1, 1, 1, 0, 1, 1, 1, 0};
`endif

    // Reset state with requests pending: nothing accepted, outputs cleared.
    model_reset();
    drive(1'b1, 32'h100, 1'b1, 4'h3, 32'h8, 32'h1, 11'h7FF);
    chk("rst_accept_i", 32'(mem_i_accept_o), 32'd0);
    chk("rst_accept_d", 32'(mem_d_accept_o), 32'd0);
    chk("rst_ram_wr", 32'(ram_wr_o), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr_o), 32'd0);
    chk("rst_valid", 32'(mem_i_valid_o), 32'd0);
    chk("rst_ack", 32'(mem_d_ack_o), 32'd0);
    chk("rst_tag", 32'(mem_d_resp_tag_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    mem_i_rd_i = 1'b0; mem_d_rd_i = 1'b0; mem_d_wr_i = '0;

    // Directed vector table, single-requester traffic.
    for (int r = 0; r < 9; r++) begin
      if (r < 8) begin
        cycle(vecs[r].i_rd, vecs[r].pc, vecs[r].d_rd, vecs[r].d_wr, vecs[r].d_addr, 32'hA5A5_0000 + 32'(r), vecs[r].tag);
        chk("vec_accept_i", 32'(mem_i_accept_o), 32'(vecs[r].acc_i));
        chk("vec_accept_d", 32'(mem_d_accept_o), 32'(vecs[r].acc_d));
        chk("vec_ram_addr", 32'(ram_addr_o), 32'(vecs[r].addr));
        chk("vec_ram_wr", 32'(ram_wr_o), 32'(vecs[r].wr));
      end else begin
        cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0);
      end
      if (r > 0) begin
        chk("vec_valid", 32'(mem_i_valid_o), 32'(vecs[r-1].nxt_valid));
        chk("vec_ack", 32'(mem_d_ack_o), 32'(vecs[r-1].nxt_ack));
        chk("vec_tag", 32'(mem_d_resp_tag_o), 32'(vecs[r-1].nxt_tag));
      end
    end

    // Contention: one I-only fetch so the last grant is I, then both sides hammer.
    cycle(1'b1, 32'h200, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 32'h300 + 32'(4 * k), 1'b1, 4'h0, 32'h500 + 32'(4 * k), 32'h0, 11'(k));
      chk("seq_grant_d", 32'(mem_d_accept_o), 32'(exp_seq_d[k]));
      chk("seq_grant_i", 32'(mem_i_accept_o), 32'(!exp_seq_d[k]));
    end
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0);

    // Reset lands on the edge that would register a D accept: no ack may follow.
    cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0, 11'h123);
    #1 rst_i = 1'b1;
    @(negedge clk_i); #2;
    chk("mid_rst_ack", 32'(mem_d_ack_o), 32'd0);
    chk("mid_rst_accept_d", 32'(mem_d_accept_o), 32'd0);
    chk("mid_rst_tag", 32'(mem_d_resp_tag_o), 32'd0);
    chk("mid_rst_addr", 32'(ram_addr_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    mem_d_rd_i = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic ir, dr;
      logic [3:0] dw;
      ir = ($urandom_range(0, 9) < 6);
      dr = 1'b0; dw = 4'h0;
      if ($urandom_range(0, 9) < 6) begin
        if ($urandom_range(0, 1) == 0) dr = 1'b1;
        else dw = 4'($urandom_range(1, 15));
      end
      cycle(ir, $urandom, dr, dw, $urandom, $urandom, 11'($urandom));
    end
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
